// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Stream layout: 2 header bytes, 4 bytes per word, 1 checksum byte.
package instr_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CHK,
      DONE,
      ERR
   } state_t;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;
   localparam int CHK_BYTES  = 1;

   // States in which a stream byte can be taken; the loader never stalls in them.
   function automatic logic takes_bytes(state_t s);
      return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHK);
   endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction RAM write port of the loader.
// master is the byte source / RAM side, slave is the loader itself.
interface instr_mem_loader_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  byte_valid;
   logic [7:0]            byte_data;
   logic                  byte_ready;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   modport master (
      output byte_valid, byte_data,
      input  byte_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs payload bytes little-endian into 32-bit words and keeps the running XOR.
// word_valid is the registered one-cycle write pulse following the fourth byte.
module word_assembler
   import instr_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_in,
   output logic        word_last,
   output logic        word_valid,
   output logic [31:0] word,
   output logic [7:0]  chk
);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] shift_q, shift_d;
   logic [31:0] word_q, word_d;
   logic        word_valid_q, word_valid_d;
   logic [7:0]  chk_q, chk_d;

   always_comb begin
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      word_d       = word_q;
      chk_d        = chk_q;
      word_last    = accept && (cnt_q == 2'(WORD_BYTES - 1));
      word_valid_d = word_last;
      if (clear) begin
         cnt_d = 2'd0;
         chk_d = 8'h00;
      end else if (accept) begin
         cnt_d   = cnt_q + 2'd1;
         // Shifting right leaves byte 0 in the low lane after three bytes.
         shift_d = {byte_in, shift_q[23:8]};
         chk_d   = chk_q ^ byte_in;
         if (word_last) begin
            word_d = {byte_in, shift_q};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= 2'd0;
         shift_q      <= 24'h0;
         word_q       <= 32'h0;
         word_valid_q <= 1'b0;
         chk_q        <= 8'h00;
      end else begin
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         chk_q        <= chk_d;
      end
   end

   assign word_valid = word_valid_q;
   assign word       = word_q;
   assign chk        = chk_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into instruction RAM
// and holds the core in reset until the image has been verified.
module instr_mem_loader
   import instr_loader_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   instr_mem_loader_if.slave  bus,
   output logic               cpu_hold,
   output logic               busy,
   output logic               done,
   output logic               error
);

   localparam logic [31:0] CAPACITY = 32'(2 ** ADDR_WIDTH);

   state_t                  state_q, state_d;
   logic [7:0]              len_lo_q, len_lo_d;
   logic [15:0]             n_q, n_d;
   logic [ADDR_WIDTH:0]     word_idx_q, word_idx_d;
   logic [DATA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic                    busy_q, busy_d;
   logic                    cpu_hold_q, cpu_hold_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;

   logic        accept;
   logic        clear;
   logic        word_last;
   logic        word_valid;
   logic [31:0] word;
   logic [7:0]  chk;
   logic [15:0] n_in;

   assign bus.byte_ready = takes_bytes(state_q);
   assign accept         = bus.byte_valid && bus.byte_ready;
   assign n_in           = {bus.byte_data, len_lo_q};

   word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .accept     (accept && (state_q == DATA)),
      .byte_in    (bus.byte_data),
      .word_last  (word_last),
      .word_valid (word_valid),
      .word       (word),
      .chk        (chk)
   );

   always_comb begin
      state_d    = state_q;
      len_lo_d   = len_lo_q;
      n_d        = n_q;
      word_idx_d = word_idx_q;
      mem_addr_d = mem_addr_q;
      busy_d     = busy_q;
      cpu_hold_d = cpu_hold_q;
      done_d     = done_q;
      error_d    = error_q;
      clear      = 1'b0;
      unique case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d    = LEN_LO;
               clear      = 1'b1;
               word_idx_d = '0;
               busy_d     = 1'b1;
               cpu_hold_d = 1'b1;
               done_d     = 1'b0;
               error_d    = 1'b0;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_lo_d = bus.byte_data;
               state_d  = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               n_d = n_in;
               if (32'(n_in) > CAPACITY) begin
                  state_d = ERR;
                  busy_d  = 1'b0;
                  error_d = 1'b1;
               end else if (n_in == 16'd0) begin
                  state_d = CHK;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (word_last) begin
               mem_addr_d = DATA_WIDTH'(BASE_ADDR) + DATA_WIDTH'({word_idx_q, 2'b00});
               word_idx_d = word_idx_q + 1'b1;
               if (32'(word_idx_q) + 32'd1 == 32'(n_q)) begin
                  state_d = CHK;
               end
            end
         end
         CHK: begin
            if (accept) begin
               busy_d = 1'b0;
               if (bus.byte_data == chk) begin
                  state_d    = DONE;
                  done_d     = 1'b1;
                  cpu_hold_d = 1'b0;
               end else begin
                  state_d = ERR;
                  error_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         len_lo_q   <= 8'h00;
         n_q        <= 16'h0;
         word_idx_q <= '0;
         mem_addr_q <= '0;
         busy_q     <= 1'b0;
         cpu_hold_q <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_lo_q   <= len_lo_d;
         n_q        <= n_d;
         word_idx_q <= word_idx_d;
         mem_addr_q <= mem_addr_d;
         busy_q     <= busy_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign bus.mem_we    = word_valid;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = DATA_WIDTH'(word);
   assign busy          = busy_q;
   assign cpu_hold      = cpu_hold_q;
   assign done          = done_q;
   assign error         = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: drives byte-stream images and checks
// RAM writes and status flags against hand-computed values.
module tb_instr_mem_loader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic cpu_hold, busy, done, error;

   int assert_count = 0;
   int fail_count   = 0;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   instr_mem_loader_if #(.DATA_WIDTH(32)) bus ();

   instr_mem_loader #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (10),
      .BASE_ADDR  (32'h0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bus      (bus),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   // Log every RAM write half a cycle away from the active edge.
   always @(negedge clk) begin
      if (bus.mem_we) begin
         wr_addr.push_back(bus.mem_addr);
         wr_data.push_back(bus.mem_wdata);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assert_count++;
      if (got !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int gap);
      int waited;
      bus.byte_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      waited = 0;
      while (!bus.byte_ready && waited < 20) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (waited >= 20) checkOutput("byte_accept_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      bus.byte_valid = 1'b0;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clearLog();
      wr_addr.delete();
      wr_data.delete();
   endtask

   initial begin
      logic [7:0] img2[10];
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      idle(2);
      rst = 1'b0;

      // Reset state
      checkOutput("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
      checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
      checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
      checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0);
      checkOutput("rst_flags", {28'h0, cpu_hold, busy, done, error}, 32'h0);

      // Single word
      clearLog();
      pulseStart();
      checkOutput("t1_busy_hold", {30'h0, busy, cpu_hold}, 32'h3);
      checkOutput("t1_ready", 32'(bus.byte_ready), 32'd1);
      foreach (img2[i]) img2[i] = 8'h00;
      applyStimulus(8'h01, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h13, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h13, 0);
      idle(3);
      checkOutput("t1_writes", 32'(wr_addr.size()), 32'd1);
      if (wr_addr.size() == 1) begin
         checkOutput("t1_addr", wr_addr[0], 32'h0);
         checkOutput("t1_data", wr_data[0], 32'h0000_0013);
      end
      checkOutput("t1_flags", {28'h0, cpu_hold, busy, done, error}, 32'h2);

      // Two words with random gaps, started from DONE
      clearLog();
      img2 = '{8'h02, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hF0, 8'hFF};
      pulseStart();
      checkOutput("t2_done_cleared", 32'(done), 32'd0);
      foreach (img2[i]) applyStimulus(img2[i], $urandom_range(0, 3));
      applyStimulus(8'hF3, $urandom_range(0, 3));
      idle(3);
      checkOutput("t2_writes", 32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() == 2) begin
         checkOutput("t2_addr0", wr_addr[0], 32'h0);
         checkOutput("t2_data0", wr_data[0], 32'h0000_006F);
         checkOutput("t2_addr1", wr_addr[1], 32'h4);
         checkOutput("t2_data1", wr_data[1], 32'hFFF0_0093);
      end
      checkOutput("t2_flags", {28'h0, cpu_hold, busy, done, error}, 32'h2);

      // Wrong checksum
      clearLog();
      pulseStart();
      applyStimulus(8'h01, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h13, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h12, 0);
      idle(3);
      checkOutput("t3_writes", 32'(wr_addr.size()), 32'd1);
      if (wr_data.size() == 1) checkOutput("t3_data", wr_data[0], 32'h0000_0013);
      checkOutput("t3_flags", {28'h0, cpu_hold, busy, done, error}, 32'h9);

      // Empty load, started from ERR
      clearLog();
      pulseStart();
      checkOutput("t4_error_cleared", 32'(error), 32'd0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0);
      idle(3);
      checkOutput("t4_writes", 32'(wr_addr.size()), 32'd0);
      checkOutput("t4_flags", {28'h0, cpu_hold, busy, done, error}, 32'h2);

      // Oversized length: 1025 words with a 1024-word RAM
      clearLog();
      pulseStart();
      applyStimulus(8'h01, 0);
      applyStimulus(8'h04, 0);
      checkOutput("t5_ready_off", 32'(bus.byte_ready), 32'd0);
      idle(3);
      checkOutput("t5_flags", {28'h0, cpu_hold, busy, done, error}, 32'h9);
      checkOutput("t5_writes", 32'(wr_addr.size()), 32'd0);

      // Abort a 3-word load after six payload bytes, then reload
      clearLog();
      pulseStart();
      applyStimulus(8'h03, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h11, 0);
      applyStimulus(8'h22, 0);
      applyStimulus(8'h33, 0);
      applyStimulus(8'h44, 0);
      applyStimulus(8'h55, 0);
      applyStimulus(8'h66, 0);
      idle(1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("t6_flags", {28'h0, cpu_hold, busy, done, error}, 32'h0);
      checkOutput("t6_ready", 32'(bus.byte_ready), 32'd0);
      checkOutput("t6_mem_addr", bus.mem_addr, 32'h0);
      checkOutput("t6_mem_wdata", bus.mem_wdata, 32'h0);
      idle(3);
      checkOutput("t6_writes", 32'(wr_addr.size()), 32'd1);
      if (wr_data.size() == 1) checkOutput("t6_data", wr_data[0], 32'h4433_2211);

      clearLog();
      pulseStart();
      applyStimulus(8'h01, 1);
      applyStimulus(8'h00, 0);
      applyStimulus(8'hAA, 2);
      applyStimulus(8'hBB, 0);
      applyStimulus(8'hCC, 1);
      applyStimulus(8'hDD, 0);
      applyStimulus(8'h00, 0);
      idle(3);
      checkOutput("t7_writes", 32'(wr_addr.size()), 32'd1);
      if (wr_addr.size() == 1) begin
         checkOutput("t7_addr", wr_addr[0], 32'h0);
         checkOutput("t7_data", wr_data[0], 32'hDDCC_BBAA);
      end
      checkOutput("t7_flags", {28'h0, cpu_hold, busy, done, error}, 32'h2);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream and writes 32-bit words into instruction RAM.
- Holds the core in reset while the load is in progress, and releases it only after the image is written and its checksum is verified.
- Sits between a byte source (UART RX / testbench driver) and the instruction RAM write port. The word format matches the fetch side: little-endian, word-aligned byte addresses, address bits [ADDR_WIDTH+1:2] select the word.

Parameters:
- DATA_WIDTH, 32, instruction word width; only 32 is supported.
- ADDR_WIDTH, 10, word-address width; capacity is 2**ADDR_WIDTH words.
- BASE_ADDR, 0, byte address of the first word written; must be 4-aligned.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins a load
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  write strobe to instruction RAM
- mem_addr  out  DATA_WIDTH  byte address of the write
- mem_wdata  out  DATA_WIDTH  word to write
- cpu_hold  out  1  holds the core in reset
- busy  out  1  a load is in progress
- done  out  1  last load succeeded (sticky)
- error  out  1  last load failed (sticky)

Behaviour:
- Reset (synchronous):
  - State goes to IDLE.
  - All outputs are 0: byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error.
  - Word counter, byte counter and checksum clear.
  - Reset asserted mid-load aborts the load immediately. No further mem_we. Words already written stay in RAM.
- Handshake: a byte is accepted when byte_valid && byte_ready on a rising clk edge. byte_ready is combinationally high exactly in states LEN_LO, LEN_HI, DATA and CHK. The loader never stalls inside these states.
- Stream format:
  - len_lo, len_hi: word count N, 16-bit, little-endian.
  - 4*N payload bytes, little-endian per word.
  - One checksum byte, equal to the XOR of all payload bytes.
- FSM:
  - IDLE -> LEN_LO on start.
  - LEN_LO -> LEN_HI on accept.
  - LEN_HI, on accept:
    - N > 2**ADDR_WIDTH -> ERR.
    - N == 0 -> CHK.
    - otherwise -> DATA.
  - DATA: accumulates bytes into a word (byte k goes to bits [8k+7:8k]).
    - On acceptance of byte 3, the following cycle drives mem_we=1 for exactly one cycle, with mem_addr = BASE_ADDR + 4*word_idx and mem_wdata = the assembled word.
    - After the Nth word -> CHK.
  - CHK, on accept: the received byte equals the running XOR -> DONE; otherwise -> ERR.
  - DONE: done=1, cpu_hold=0.
  - ERR: error=1, cpu_hold=1.
  - start in DONE or ERR clears done/error and goes to LEN_LO. start in any other state is ignored.
- cpu_hold and busy:
  - Both are registered and go 1 in the cycle after start is accepted.
  - busy falls on entry to DONE or ERR.
  - cpu_hold falls only on entry to DONE.
- Counter widths: byte counter is 2 bits and wraps 3 -> 0 at each word. The word counter is ADDR_WIDTH+1 bits, so N = 2**ADDR_WIDTH is legal.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Latency: the last payload byte accepted at edge t produces mem_we at edge t+1. done rises at the edge after the checksum byte is accepted.

Decomposition:
- instr_loader_pkg:
  - state enum: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR.
  - constants: HDR_BYTES=2, WORD_BYTES=4, CHK_BYTES=1.
- Sub-module word_assembler: byte shift-in, 2-bit byte counter, word-complete pulse and running XOR. It is cleared by the FSM on start.

Test Plan:
- Single word: start; bytes 01 00 13 00 00 00, then 13 -> one mem_we with mem_addr=0x0, mem_wdata=0x00000013; done=1; cpu_hold 1 -> 0.
- Two words with byte_valid gaps of 0–3 random cycles; payload 0x0000006F, 0xFFF00093 -> writes at 0x0 and 0x4 with exact data; checksum accepted; done=1.
- Wrong checksum (payload as in the single-word case, checksum 0x12) -> word still written; error=1, done=0, cpu_hold stays 1, busy=0.
- Empty load: bytes 00 00 00 -> no mem_we; done=1.
- N=1025 (bytes 01 04) with ADDR_WIDTH=10 -> error asserted after the header; byte_ready=0 afterwards; no mem_we.
- Abort and restart:
  - rst pulsed after the 6th payload byte of a 3-word load -> all outputs 0; exactly one mem_we occurred before reset.
  - A subsequent start with a valid image -> completes with done=1.
